// File: rtl/periph_cmd_bridge_if.sv
// periph_cmd_bridge_if: register-side and RoJoBot-side signals of the command bridge.
`timescale 1ns/1ps
interface periph_cmd_bridge_if;
    logic [31:0] cmd_reg_i;
    logic [31:0] sts_reg_o;
    logic        bot_req_o;
    logic [23:0] bot_cmd_o;
    logic        bot_ack_i;
    logic [7:0]  bot_rsp_i;
    logic        irq_o;
    modport slave (
        input  cmd_reg_i, bot_ack_i, bot_rsp_i,
        output sts_reg_o, bot_req_o, bot_cmd_o, irq_o
    );
    modport master (
        output cmd_reg_i, bot_ack_i, bot_rsp_i,
        input  sts_reg_o, bot_req_o, bot_cmd_o, irq_o
    );
endinterface

// File: rtl/periph_cmd_bridge.sv
// periph_cmd_bridge: queues toggle-posted register commands and issues them over req/ack with timeout.
// Optional completion interrupt enabled by defining PERIPH_CMD_IRQ_EN.
`timescale 1ns/1ps
module periph_cmd_bridge #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input logic wb_clk_i,
    input logic wb_rst_i,
    periph_cmd_bridge_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] REQ  = 1'b1;

    logic [0:0]    state;
    logic          seq_prev, seq_echo, ovf, tout, req;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level;
    logic [7:0]    done_cnt, rsp;
    logic [15:0]   tcnt;
    logic [23:0]   cmd_q;
    logic [31:0]   sts;
    logic [23:0]   mem [DEPTH];
    logic          irq_pend;

    // full/empty come from the registered level, so a same-cycle pop never frees a slot for a push
    wire ev       = bus.cmd_reg_i[31] ^ seq_prev;
    wire clr      = ev & bus.cmd_reg_i[30];
    wire post     = ev & ~bus.cmd_reg_i[30];
    wire full     = level == LW'(DEPTH);
    wire empty    = level == '0;
    wire push     = post & ~full;
    wire drop     = post & full;
    wire pop      = state == IDLE & ~empty;
    wire ack_done = state == REQ & bus.bot_ack_i;
    wire to_hit   = state == REQ & ~bus.bot_ack_i & tcnt == 16'(TIMEOUT - 1);

    always_ff @(posedge wb_clk_i)
        if (push) mem[wr_ptr] <= bus.cmd_reg_i[23:0];

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state    <= IDLE;
            seq_prev <= 1'b0;
            seq_echo <= 1'b0;
            ovf      <= 1'b0;
            tout     <= 1'b0;
            req      <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            done_cnt <= '0;
            rsp      <= '0;
            tcnt     <= '0;
            cmd_q    <= '0;
            sts      <= '0;
        end else begin
            seq_prev <= bus.cmd_reg_i[31];
            seq_echo <= push ? bus.cmd_reg_i[31] : seq_echo;
            ovf      <= drop ? 1'b1 : clr ? 1'b0 : ovf;
            tout     <= to_hit ? 1'b1 : clr ? 1'b0 : tout;
            wr_ptr   <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr   <= pop ? rd_ptr + AW'(1) : rd_ptr;
            level    <= level + LW'(push) - LW'(pop);
            done_cnt <= ack_done ? done_cnt + 8'd1 : done_cnt;
            rsp      <= ack_done ? bus.bot_rsp_i : rsp;
            cmd_q    <= pop ? mem[rd_ptr] : cmd_q;
            req      <= pop ? 1'b1 : (ack_done | to_hit) ? 1'b0 : req;
            tcnt     <= pop ? 16'd0 : state == REQ ? tcnt + 16'd1 : tcnt;
            state    <= pop ? REQ : (ack_done | to_hit) ? IDLE : state;
            sts      <= {seq_echo, state == REQ, full, empty, ovf, tout, irq_pend, 1'b0,
                         done_cnt, 8'(level), rsp};
        end
    end

`ifdef PERIPH_CMD_IRQ_EN
    logic irq;
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            irq      <= 1'b0;
            irq_pend <= 1'b0;
        end else begin
            irq      <= ack_done;
            irq_pend <= ack_done ? 1'b1 : clr ? 1'b0 : irq_pend;
        end
    end
    assign bus.irq_o = irq;
`else
    assign irq_pend  = 1'b0;
    assign bus.irq_o = 1'b0;
`endif

    assign bus.bot_req_o = req;
    assign bus.bot_cmd_o = cmd_q;
    assign bus.sts_reg_o = sts;
endmodule

// File: tb/tb_periph_cmd_bridge.sv
// tb_periph_cmd_bridge: directed test of periph_cmd_bridge with DEPTH=4, TIMEOUT=16.
`timescale 1ns/1ps
module tb_periph_cmd_bridge;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    int n;
    bit seen;

    periph_cmd_bridge_if bus();

    periph_cmd_bridge #(.DEPTH(4), .TIMEOUT(16)) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.cmd_reg_i = '0;
        bus.bot_ack_i = 1'b0;
        bus.bot_rsp_i = '0;
        #1;
        chk("rst_sts", bus.sts_reg_o, 32'h0);
        chk("rst_req", 32'(bus.bot_req_o), 32'h0);
        tick(2);
        rst = 1'b0;
        tick(2);
        chk("idle_sts", bus.sts_reg_o, 32'h1000_0000);
        chk("idle_req", 32'(bus.bot_req_o), 32'h0);

        // single command, ack after 3 cycles
        bus.cmd_reg_i = 32'h8000_ABCD;
        tick(2);
        chk("t2_req", 32'(bus.bot_req_o), 32'h1);
        chk("t2_cmd", 32'(bus.bot_cmd_o), 32'h0000_ABCD);
        tick(1);
        chk("t2_busy_sts", bus.sts_reg_o, 32'hD000_0000);
        tick(1);
        bus.bot_ack_i = 1'b1;
        bus.bot_rsp_i = 8'h5A;
        tick(1);
        bus.bot_ack_i = 1'b0;
        bus.bot_rsp_i = 8'h00;
        chk("t2_req_drop", 32'(bus.bot_req_o), 32'h0);
        tick(1);
        chk("t2_sts", bus.sts_reg_o, 32'h9001_005A);
        chk("t2_irq", 32'(bus.irq_o), 32'h0);

        // six posts without ack: one in flight, four queued, one dropped
        bus.cmd_reg_i = 32'h0000_0001; tick(1);
        bus.cmd_reg_i = 32'h8000_0002; tick(1);
        bus.cmd_reg_i = 32'h0000_0003; tick(1);
        bus.cmd_reg_i = 32'h8000_0004; tick(1);
        bus.cmd_reg_i = 32'h0000_0005; tick(1);
        bus.cmd_reg_i = 32'h8000_0006; tick(1);
        tick(1);
        chk("t3_sts", bus.sts_reg_o, 32'h6801_045A);
        chk("t3_req", 32'(bus.bot_req_o), 32'h1);
        chk("t3_cmd", 32'(bus.bot_cmd_o), 32'h0000_0001);

        // timeout of the in-flight command, then next command high exactly 16 cycles
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick(1);
            seen = !bus.bot_req_o;
        end
        chk("t4_first_timeout", 32'(seen), 32'h1);
        tick(1);
        chk("t4_next_req", 32'(bus.bot_req_o), 32'h1);
        chk("t4_next_cmd", 32'(bus.bot_cmd_o), 32'h0000_0002);
        n = 1;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick(1);
            if (bus.bot_req_o) n++;
            else seen = 1'b1;
        end
        chk("t4_req_cycles", 32'(n), 32'd16);

        // clear event lands on the timeout cycle: set wins
        tick(1);
        chk("t5_cmd3", 32'(bus.bot_cmd_o), 32'h0000_0003);
        tick(15);
        bus.cmd_reg_i = 32'h4000_0000;
        tick(1);
        chk("t5_req_drop", 32'(bus.bot_req_o), 32'h0);
        tick(1);
        chk("t5_sts_set_wins", bus.sts_reg_o, 32'h0401_025A);
        bus.cmd_reg_i = 32'hC000_0000;
        tick(2);
        chk("t5_sts_cleared", bus.sts_reg_o, 32'h4001_015A);

        // reset in the middle of a request with three queued
        bus.cmd_reg_i = 32'h0000_0007; tick(1);
        bus.cmd_reg_i = 32'h8000_0008; tick(1);
        chk("t6_req_before", 32'(bus.bot_req_o), 32'h1);
        chk("t6_level_before", 32'(bus.sts_reg_o[15:8]), 32'h2);
        tick(1);
        chk("t6_level3", 32'(bus.sts_reg_o[15:8]), 32'h3);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_req_async", 32'(bus.bot_req_o), 32'h0);
        chk("t6_sts_async", bus.sts_reg_o, 32'h0);
        bus.cmd_reg_i = '0;
        tick(2);
        rst = 1'b0;
        tick(2);
        chk("t6_sts_after", bus.sts_reg_o, 32'h1000_0000);
        chk("t6_req_after", 32'(bus.bot_req_o), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
